// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and winner-select rule for mem_bus_arbiter.
// Define ARB_ROUND_ROBIN_EN to alternate the winner on a tie; otherwise D has fixed priority.
package mem_bus_arbiter_pkg;

    typedef enum logic [1:0] {IDLE, HOLD, RESP} ArbState;
    typedef enum logic {INST, DATA} ArbOwner;

`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    // A lone requester always wins; ties go to D unless round-robin hands it to whoever did not win last.
    function automatic ArbOwner arb_pick(logic i_req, logic d_req, ArbOwner last);
        if (i_req && d_req)
            return (!RR_EN || last == INST) ? DATA : INST;
        return d_req ? DATA : INST;
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Requester-side and memory-side signals of the arbiter.
// master = the arbiter's view, slave = the surrounding requesters and memory.
interface mem_bus_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int BE_W = DATA_W / 8;

    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_gnt;
    logic              i_rvalid;
    logic [DATA_W-1:0] i_rdata;
    logic              i_err;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [BE_W-1:0]   d_be;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;
    logic              d_err;

    logic              m_req;
    logic              m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic [BE_W-1:0]   m_be;
    logic              m_gnt;
    logic              m_rvalid;
    logic [DATA_W-1:0] m_rdata;

    modport master (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_be, m_gnt, m_rvalid, m_rdata,
        output i_gnt, i_rvalid, i_rdata, i_err, d_gnt, d_rvalid, d_rdata, d_err,
        output m_req, m_we, m_addr, m_wdata, m_be
    );

    modport slave (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_be, m_gnt, m_rvalid, m_rdata,
        input  i_gnt, i_rvalid, i_rdata, i_err, d_gnt, d_rvalid, d_rdata, d_err,
        input  m_req, m_we, m_addr, m_wdata, m_be
    );
endinterface

// File: rtl/mem_bus_arbiter_timer.sv
// Response watchdog: counts RESP cycles and flags the last one allowed before an error reply.
// TIMEOUT_CYCLES=0 removes the watchdog entirely.
module bus_timeout_timer #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic run,
    output logic expired
);
    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    generate
        if (TIMEOUT_CYCLES == 0) begin : g_off
            assign expired = 1'b0;
        end else begin : g_on
            localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);
            logic [CW-1:0] r_cnt;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    r_cnt <= '0;
                else if (clear)
                    r_cnt <= '0;
                else if (run)
                    r_cnt <= r_cnt + 1'b1;
            end

            assign expired = run && (r_cnt == LIMIT);
        end
    endgenerate
endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one memory port between fetch (I) and load/store (D); one transaction in flight.
// Tie-break policy selected by ARB_ROUND_ROBIN_EN (see mem_bus_arbiter_pkg).
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input logic               clk,
    input logic               rst_n,
    mem_bus_arbiter_if.master bus
);
    localparam int BE_W = DATA_W / 8;

    ArbState r_state;
    ArbOwner r_sel, r_owner, r_last;
    logic    r_we;

    ArbOwner w_win, w_src;
    logic    w_req, w_gnt, w_resp, w_expired, w_i_rv, w_d_rv;

    assign w_win  = arb_pick(bus.i_req, bus.d_req, r_last);
    // Once in HOLD the latched winner drives the bus even if a new request appears.
    assign w_src  = (r_state == HOLD) ? r_sel : w_win;
    assign w_req  = rst_n && ((r_state == IDLE && (bus.i_req || bus.d_req)) || r_state == HOLD);
    assign w_gnt  = w_req && bus.m_gnt;
    assign w_resp = rst_n && (r_state == RESP) && (bus.m_rvalid || w_expired);
    assign w_i_rv = w_resp && (r_owner == INST);
    assign w_d_rv = w_resp && (r_owner == DATA);

    bus_timeout_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   ((r_state != RESP) || w_resp),
        .run     (r_state == RESP),
        .expired (w_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_sel   <= INST;
            r_owner <= INST;
            r_last  <= INST;
            r_we    <= 1'b0;
        end else begin
            case (r_state)
                IDLE, HOLD: begin
                    if (w_gnt) begin
                        r_owner <= w_src;
                        r_last  <= w_src;
                        r_we    <= (w_src == DATA) && bus.d_we;
                        r_state <= RESP;
                    end else if (w_req && r_state == IDLE) begin
                        r_sel   <= w_win;
                        r_state <= HOLD;
                    end
                end
                RESP:    if (w_resp) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    always_comb begin
        bus.m_req   = w_req;
        bus.m_we    = w_req && (w_src == DATA) && bus.d_we;
        bus.m_addr  = '0;
        bus.m_wdata = '0;
        bus.m_be    = '0;
        if (w_req) begin
            if (w_src == DATA) begin
                bus.m_addr  = bus.d_addr;
                bus.m_wdata = bus.d_wdata;
                bus.m_be    = bus.d_be;
            end else begin
                bus.m_addr  = bus.i_addr;
                bus.m_be    = {BE_W{1'b1}};
            end
        end

        bus.i_gnt    = w_gnt && (w_src == INST);
        bus.d_gnt    = w_gnt && (w_src == DATA);
        bus.i_rvalid = w_i_rv;
        bus.d_rvalid = w_d_rv;
        // A real slave answer wins over a coincident watchdog expiry.
        bus.i_err    = w_i_rv && !bus.m_rvalid;
        bus.d_err    = w_d_rv && !bus.m_rvalid;
        bus.i_rdata  = (w_i_rv && bus.m_rvalid) ? bus.m_rdata : '0;
        bus.d_rdata  = (w_d_rv && bus.m_rvalid && !r_we) ? bus.m_rdata : '0;
    end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomized scoreboard bench for mem_bus_arbiter; the driver schedules each transaction
// from the arbitration rules and queues expected bus/response events for the monitor.
module tb_mem_bus_arbiter;
    localparam int TO = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus();

    mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int          cyc;
        bit          who_d;
        bit          gnt;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } mreq_t;

    typedef struct {
        int          cyc;
        bit          who_d;
        bit          err;
        logic [31:0] rdata;
    } rsp_t;

    mreq_t mq[$];
    rsp_t  rq[$];
    int    cyc = 0;
    int    n_chk = 0;
    int    n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Monitor: consumes expected events whenever the DUT presents a request or a response.
    always @(negedge clk) begin
        mreq_t m;
        rsp_t  r;
        if (!rst_n) begin
            check("reset_outputs_zero", 64'(|{bus.m_req, bus.m_we, bus.m_addr, bus.m_wdata, bus.m_be,
                  bus.i_gnt, bus.i_rvalid, bus.i_rdata, bus.i_err,
                  bus.d_gnt, bus.d_rvalid, bus.d_rdata, bus.d_err}), 64'd0);
        end else begin
            while (mq.size() > 0 && mq[0].cyc < cyc) begin
                m = mq.pop_front();
                check("mreq_missing_cycle", 64'(cyc), 64'(m.cyc));
            end
            if (bus.m_req) begin
                if (mq.size() == 0) begin
                    check("m_req_unexpected", 64'(bus.m_req), 64'd0);
                end else begin
                    m = mq.pop_front();
                    check("mreq_cycle", 64'(cyc), 64'(m.cyc));
                    check("m_addr", 64'(bus.m_addr), 64'(m.addr));
                    check("m_we", 64'(bus.m_we), 64'(m.we));
                    check("m_be", 64'(bus.m_be), 64'(m.be));
                    if (m.who_d && m.we) check("m_wdata", 64'(bus.m_wdata), 64'(m.wdata));
                    check("gnt_id", 64'({bus.i_gnt, bus.d_gnt}),
                          64'({m.gnt && !m.who_d, m.gnt && m.who_d}));
                end
            end else if (bus.i_gnt || bus.d_gnt) begin
                check("gnt_without_m_req", 64'({bus.i_gnt, bus.d_gnt}), 64'd0);
            end

            while (rq.size() > 0 && rq[0].cyc < cyc) begin
                r = rq.pop_front();
                check("rsp_missing_cycle", 64'(cyc), 64'(r.cyc));
            end
            if (bus.i_rvalid || bus.d_rvalid) begin
                if (rq.size() == 0) begin
                    check("rvalid_unexpected", 64'({bus.i_rvalid, bus.d_rvalid}), 64'd0);
                end else begin
                    r = rq.pop_front();
                    check("rsp_cycle", 64'(cyc), 64'(r.cyc));
                    check("rsp_id", 64'({bus.i_rvalid, bus.d_rvalid}), 64'({!r.who_d, r.who_d}));
                    check("rsp_err", 64'(r.who_d ? bus.d_err : bus.i_err), 64'(r.err));
                    check("rsp_rdata", 64'(r.who_d ? bus.d_rdata : bus.i_rdata), 64'(r.rdata));
                    check("other_side_quiet", 64'(r.who_d ? {bus.i_err, bus.i_rdata} : {bus.d_err, bus.d_rdata}), 64'd0);
                end
            end else if (bus.i_err || bus.d_err || (|bus.i_rdata) || (|bus.d_rdata)) begin
                check("resp_outputs_idle", 64'(|{bus.i_err, bus.d_err, bus.i_rdata, bus.d_rdata}), 64'd0);
            end
        end
    end

    // Driver-side requester state and model
    bit          i_live, d_live, last_d;
    int          i_raise, d_raise;
    logic [31:0] i_addr_v, d_addr_v, d_wdata_v;
    logic        d_we_v;
    logic [3:0]  d_be_v;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reqs();
        bus.i_req   = i_live && (cyc >= i_raise);
        bus.i_addr  = i_addr_v;
        bus.d_req   = d_live && (cyc >= d_raise);
        bus.d_we    = d_we_v;
        bus.d_addr  = d_addr_v;
        bus.d_wdata = d_wdata_v;
        bus.d_be    = d_be_v;
    endtask

    function automatic bit pick_d(bit ri, bit rd);
        if (ri && rd) begin
`ifdef ARB_ROUND_ROBIN_EN
            return !last_d;
`else
            return 1'b1;
`endif
        end
        return rd;
    endfunction

    // mode: 0 I only, 1 D only, 2 I first then D after `late`, 3 D first then I after `late`.
    // g_f: forced m_gnt delay (-1 random); r_f: forced response delay (0 timeout, -1 random).
    task automatic scenario(int mode, int late, int g_f, int r_f);
        bit          ri, rd, wd, tmo;
        int          g, r, t_rsp;
        logic [31:0] rdv;
        mreq_t       m;
        rsp_t        rs;
        i_addr_v  = $urandom;
        d_addr_v  = $urandom;
        d_wdata_v = $urandom;
        d_we_v    = 1'($urandom_range(0, 1));
        d_be_v    = 4'($urandom_range(0, 15));
        i_live    = (mode != 1);
        d_live    = (mode != 0);
        i_raise   = cyc + ((mode == 3) ? late : 0);
        d_raise   = cyc + ((mode == 2) ? late : 0);
        apply_reqs();
        while (i_live || d_live) begin
            ri  = i_live && (cyc >= i_raise);
            rd  = d_live && (cyc >= d_raise);
            wd  = pick_d(ri, rd);
            g   = (g_f >= 0) ? g_f : int'($urandom_range(0, 3));
            tmo = (r_f == 0) || (r_f < 0 && $urandom_range(0, 5) == 0);
            r   = tmo ? TO : ((r_f > 0) ? r_f : int'($urandom_range(1, 3)));
            for (int k = 0; k <= g; k++) begin
                if (k > 0) begin
                    step();
                    apply_reqs();
                end
                m.cyc   = cyc;
                m.who_d = wd;
                m.gnt   = (k == g);
                m.we    = wd && d_we_v;
                m.addr  = wd ? d_addr_v : i_addr_v;
                m.wdata = d_wdata_v;
                m.be    = wd ? d_be_v : 4'hF;
                mq.push_back(m);
                bus.m_gnt    = (k == g);
                bus.m_rvalid = ($urandom_range(0, 3) == 0);
                bus.m_rdata  = $urandom;
            end
            last_d   = wd;
            rdv      = $urandom;
            rs.cyc   = cyc + r;
            rs.who_d = wd;
            rs.err   = tmo;
            rs.rdata = (tmo || (wd && d_we_v)) ? 32'd0 : rdv;
            rq.push_back(rs);
            t_rsp = rs.cyc;
            if (wd) d_live = 1'b0;
            else    i_live = 1'b0;
            while (cyc < t_rsp) begin
                step();
                apply_reqs();
                bus.m_gnt    = 1'b0;
                bus.m_rvalid = !tmo && (cyc == t_rsp);
                bus.m_rdata  = (cyc == t_rsp) ? rdv : $urandom;
            end
            step();
            bus.m_rvalid = 1'b0;
            apply_reqs();
        end
    endtask

    task automatic reset_mid_resp();
        mreq_t m;
        i_addr_v = $urandom;
        i_live   = 1'b1;
        i_raise  = cyc;
        d_live   = 1'b0;
        apply_reqs();
        bus.m_gnt = 1'b1;
        m.cyc = cyc; m.who_d = 1'b0; m.gnt = 1'b1; m.we = 1'b0;
        m.addr = i_addr_v; m.wdata = '0; m.be = 4'hF;
        mq.push_back(m);
        step();
        i_live = 1'b0;
        apply_reqs();
        bus.m_gnt = 1'b0;
        // Requests held high during reset must not leak onto the bus.
        rst_n  = 1'b0;
        i_live = 1'b1; i_raise = cyc;
        d_live = 1'b1; d_raise = cyc;
        apply_reqs();
        step();
        step();
        i_live = 1'b0;
        d_live = 1'b0;
        apply_reqs();
        rst_n        = 1'b1;
        bus.m_rvalid = 1'b1;
        bus.m_rdata  = $urandom;
        step();
        bus.m_rvalid = 1'b0;
        last_d       = 1'b0;
        step();
    endtask

    initial begin
        i_live = 1'b0; d_live = 1'b0; last_d = 1'b0;
        i_raise = 0; d_raise = 0;
        i_addr_v = '0; d_addr_v = '0; d_wdata_v = '0; d_we_v = 1'b0; d_be_v = '0;
        apply_reqs();
        bus.m_gnt = 1'b0; bus.m_rvalid = 1'b0; bus.m_rdata = '0;
        repeat (3) step();
        rst_n = 1'b1;
        step();

        scenario(0, 0, 0, 2);   // plain fetch, same-cycle grant
        scenario(2, 0, 0, -1);  // tie
        scenario(3, 1, 3, 1);   // D held off 3 cycles, I arrives during HOLD
        scenario(0, 0, 0, 0);   // watchdog expiry
        repeat (4) scenario(2, 0, -1, -1);
        for (int n = 0; n < 150; n++) begin
            scenario(int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), -1, -1);
            repeat ($urandom_range(0, 2)) step();
        end

        reset_mid_resp();
        scenario(2, 0, -1, -1);
        repeat (6) step();

        check("mreq_queue_drained", 64'(mq.size()), 64'd0);
        check("rsp_queue_drained", 64'(rq.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
